// File: rtl/bit_expander_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_expander_pkg
// Description : Shared state encoding for the bit expander control/datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_expander_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage : bit_expander_pkg
`default_nettype wire

// File: rtl/bit_expander_control.sv
`default_nettype none
// ============================================================================
// Module      : bit_expander_control
// Description : IDLE/LOAD/SHIFT/DONE controller with registered strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_expander_control
    import bit_expander_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic cnt_is_zero,
    output logic ld,
    output logic shift,
    output logic busy,
    output logic done
);

    state_t state_q, state_d;
    logic   ld_q, ld_d;
    logic   shift_q, shift_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)       state_d = S_LOAD;
            S_LOAD:                   state_d = S_SHIFT;
            S_SHIFT: if (cnt_is_zero) state_d = S_DONE;
            S_DONE:  if (!start)      state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
        // Strobes are decoded from the next state so they line up with state_q.
        ld_d    = (state_d == S_LOAD);
        shift_d = (state_d == S_SHIFT);
        busy_d  = ld_d | shift_d;
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ld_q    <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ld    = ld_q;
    assign shift = shift_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule : bit_expander_control
`default_nettype wire

// File: rtl/bit_expander.sv
`default_nettype none
// ============================================================================
// Module      : bit_expander
// Description : Expands a count N into a WIDTH-bit thermometer word, one bit/clk.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_expander
    import bit_expander_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [CW-1:0]    count_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] word_out
);

    localparam logic [CW-1:0] c_width_cnt = CW'(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             w_ld;
    logic             w_shift;
    logic             w_cnt_is_zero;
    logic             w_sat;

    assign w_cnt_is_zero = (cnt_q == '0);
    assign w_sat         = (count_in > c_width_cnt);

    bit_expander_control u_control (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .cnt_is_zero (w_cnt_is_zero),
        .ld          (w_ld),
        .shift       (w_shift),
        .busy        (busy),
        .done        (done)
    );

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (w_ld) begin
            cnt_d   = w_sat ? c_width_cnt : count_in;
            err_d   = w_sat;
            shreg_d = '0;
        end else if (w_shift && !w_cnt_is_zero) begin
            // The zero-count SHIFT cycle is the one that hands over to DONE.
            shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
            cnt_d   = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign word_out = shreg_q;
    assign err      = err_q;

endmodule : bit_expander
`default_nettype wire

// File: tb/tb_bit_expander.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_expander
// Description : Directed self-checking bench for bit_expander (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_expander;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk;
    logic             resetn;
    logic             start;
    logic [CW-1:0]    count_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] word_out;

    int n_checks = 0;
    int n_fail   = 0;

    bit_expander #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .count_in (count_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_out (word_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn   = 1'b0;
        start    = 1'b0;
        count_in = '0;
        #3;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_checks++; if (word_out !== 8'h00) begin n_fail++; $display("FAIL reset_word got %h exp 00", word_out); end
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_count3;
        start    = 1'b1;
        count_in = 4'd3;
        for (int e = 0; e <= 5; e++) begin
            step();
            n_checks++; if (busy !== (e < 5)) begin n_fail++; $display("FAIL n3_busy edge %0d got %b exp %b", e, busy, (e < 5)); end
            n_checks++; if (done !== (e == 5)) begin n_fail++; $display("FAIL n3_done edge %0d got %b exp %b", e, done, (e == 5)); end
        end
        n_checks++; if (word_out !== 8'h07) begin n_fail++; $display("FAIL n3_word got %h exp 07", word_out); end
        n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL n3_err got %b exp 0", err); end
        start = 1'b0;
        step();
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL n3_idle_done got %b exp 0", done); end
        n_checks++; if (word_out !== 8'h07) begin n_fail++; $display("FAIL n3_hold_word got %h exp 07", word_out); end
        n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL n3_hold_err got %b exp 0", err); end
    endtask

    // Columns: requested N, edge at which done rises, expected word, expected err
    task automatic test_lengths;
        logic [CW-1:0]    req  [3] = '{4'd0, 4'd8, 4'd12};
        int               dedg [3] = '{2, 10, 10};
        logic [WIDTH-1:0] expw [3] = '{8'h00, 8'hFF, 8'hFF};
        logic             expe [3] = '{1'b0, 1'b0, 1'b1};
        for (int v = 0; v < 3; v++) begin
            start    = 1'b1;
            count_in = req[v];
            for (int e = 0; e <= dedg[v]; e++) begin
                step();
                n_checks++;
                if (done !== (e == dedg[v])) begin
                    n_fail++;
                    $display("FAIL len%0d_done edge %0d got %b exp %b", req[v], e, done, (e == dedg[v]));
                end
            end
            n_checks++; if (word_out !== expw[v]) begin n_fail++; $display("FAIL len%0d_word got %h exp %h", req[v], word_out, expw[v]); end
            n_checks++; if (err !== expe[v])      begin n_fail++; $display("FAIL len%0d_err got %b exp %b", req[v], err, expe[v]); end
            start = 1'b0;
            step();
        end
    endtask

    task automatic test_async_reset;
        start    = 1'b1;
        count_in = 4'd6;
        for (int e = 0; e <= 4; e++) step();
        n_checks++; if (word_out !== 8'h07) begin n_fail++; $display("FAIL ar_partial_word got %h exp 07", word_out); end
        n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL ar_partial_busy got %b exp 1", busy); end
        #2;
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL ar_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL ar_done got %b exp 0", done); end
        n_checks++; if (word_out !== 8'h00) begin n_fail++; $display("FAIL ar_word got %h exp 00", word_out); end
        step();
        resetn = 1'b1;
        step();
        start    = 1'b1;
        count_in = 4'd2;
        for (int e = 0; e <= 4; e++) step();
        n_checks++; if (done !== 1'b1)      begin n_fail++; $display("FAIL ar_rerun_done got %b exp 1", done); end
        n_checks++; if (word_out !== 8'h03) begin n_fail++; $display("FAIL ar_rerun_word got %h exp 03", word_out); end
        start = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        start    = 1'b1;
        count_in = 4'd5;
        for (int e = 0; e <= 7; e++) step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b exp 1", done); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_hold cyc %0d done %b busy %b exp 1 0", k, done, busy); end
        end
        n_checks++; if (word_out !== 8'h1F) begin n_fail++; $display("FAIL b2b_word got %h exp 1f", word_out); end
        start = 1'b0;
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 0", done); end
        start    = 1'b1;
        count_in = 4'd1;
        for (int e = 0; e <= 3; e++) begin
            step();
            if (e == 1) count_in = 4'd7;
            n_checks++; if (done !== (e == 3)) begin n_fail++; $display("FAIL b2b_n1_done edge %0d got %b exp %b", e, done, (e == 3)); end
        end
        n_checks++; if (word_out !== 8'h01) begin n_fail++; $display("FAIL b2b_n1_word got %h exp 01", word_out); end
        start = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_count3();
        test_lengths();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule : tb_bit_expander
`default_nettype wire
